// File: rtl/mpsoc_wb_spram_arbiter.sv
// Round-robin Wishbone arbiter sharing one mpsoc_wb_spram port among NUM_MASTERS masters.
// Optional stall timeout: define MPSOC_WB_ARB_TIMEOUT_EN.
module mpsoc_wb_spram_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DW          = 32,
  parameter int AW          = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,

  input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
  input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [DW-1:0]             wbm_dat_o,

  output logic [AW-1:0]             wbs_adr_o,
  output logic [DW-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic [1:0]                wbs_bte_o,
  output logic [2:0]                wbs_cti_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic [DW-1:0]             wbs_dat_i,

  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || TIMEOUT < 2) begin : g_bad_params
    $error("mpsoc_wb_spram_arbiter: NUM_MASTERS and TIMEOUT must both be >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  // In BUSY the most recently granted master is the granted master, so last_q
  // doubles as the grant index and no separate grant register is needed.
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  winner;
  logic           active;
  logic           gnt_cyc;
  logic           gnt_stb;
  logic           timeout_hit;

  // Reset gates everything at once so a grant drops and a late RAM ack is
  // discarded in the very cycle reset is asserted.
  assign active  = (state_q == BUSY) && !wb_rst_i;
  assign gnt_cyc = wbm_cyc_i[last_q];
  assign gnt_stb = wbm_stb_i[last_q];

  // Round-robin pick: scan last+1, last+2, ... wrapping, ending with last itself.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    winner = last_q;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (wbm_cyc_i[(int'(last_q) + k) % NUM_MASTERS]) begin
        winner = IW'((int'(last_q) + k) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|wbm_cyc_i) begin
          state_d = BUSY;
          last_d  = winner;
        end
      end
      BUSY: begin
        if (!gnt_cyc || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef MPSOC_WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] stall_q, stall_d;

  assign timeout_hit = active && gnt_stb && (stall_q == CW'(TIMEOUT - 1));

  always_comb begin
    stall_d = stall_q;
    if (state_q != BUSY || wbs_ack_i || wbs_err_i) begin
      stall_d = '0;
    end else if (gnt_stb) begin
      stall_d = stall_q + CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Request mux and response steering, combinational from the grant.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_bte_o = '0;
    wbs_cti_o = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    grant_o   = '0;
    if (active) begin
      wbs_adr_o         = wbm_adr_i[int'(last_q)*AW +: AW];
      wbs_dat_o         = wbm_dat_i[int'(last_q)*DW +: DW];
      wbs_sel_o         = wbm_sel_i[int'(last_q)*4 +: 4];
      wbs_we_o          = wbm_we_i[last_q];
      wbs_bte_o         = wbm_bte_i[int'(last_q)*2 +: 2];
      wbs_cti_o         = wbm_cti_i[int'(last_q)*3 +: 3];
      wbs_cyc_o         = gnt_cyc;
      wbs_stb_o         = gnt_stb && !timeout_hit;
      grant_o[last_q]   = 1'b1;
      wbm_ack_o[last_q] = wbs_ack_i && !timeout_hit;
      wbm_err_o[last_q] = wbs_err_i || timeout_hit;
    end
  end

  assign wbm_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_mpsoc_wb_spram_arbiter.sv
// Self-checking bench for mpsoc_wb_spram_arbiter: random masters, a behavioural RAM,
// and a per-cycle reference model of grant, request mux and response steering.
`timescale 1ns/1ps
module tb_mpsoc_wb_spram_arbiter;

  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int AW      = 8;
  localparam int TIMEOUT = 8;
`ifdef MPSOC_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic [N*AW-1:0]   wbm_adr_i = '0;
  logic [N*DW-1:0]   wbm_dat_i = '0;
  logic [N*4-1:0]    wbm_sel_i = '0;
  logic [N-1:0]      wbm_we_i  = '0;
  logic [N-1:0]      wbm_cyc_i = '0;
  logic [N-1:0]      wbm_stb_i = '0;
  logic [N*2-1:0]    wbm_bte_i = '0;
  logic [N*3-1:0]    wbm_cti_i = '0;
  logic [N-1:0]      wbm_ack_o, wbm_err_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o;
  logic [1:0]        wbs_bte_o;
  logic [2:0]        wbs_cti_o;
  logic              wbs_cyc_o, wbs_stb_o;
  logic              wbs_ack_i = 1'b0;
  logic              wbs_err_i = 1'b0;
  logic [DW-1:0]     wbs_dat_i = '0;
  logic [N-1:0]      grant_o;

  mpsoc_wb_spram_arbiter #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_bte_i(wbm_bte_i), .wbm_cti_i(wbm_cti_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_dat_o(wbm_dat_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_bte_o(wbs_bte_o), .wbs_cti_o(wbs_cti_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_dat_i(wbs_dat_i),
    .grant_o(grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    int            nbeats;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;

  // Control knobs written by the test sequence
  bit rst_req   = 1'b1;
  bit ram_stall = 1'b0;
  bit rand_lat  = 1'b0;
  bit rand_err  = 1'b0;
  bit rand_mode = 1'b0;

  // Master engine state
  txn_t          txq [N][$];
  txn_t          m_cur [N];
  bit            m_active [N];
  bit            m_resp [N];
  bit            m_errd [N];
  int            m_beat [N];
  int            m_cool [N];
  int            ack_cnt [N];
  logic [DW-1:0] rd_log [N][$];

  // Behavioural RAM
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          ram_ack_n = 1'b0;
  logic          ram_err_n = 1'b0;
  logic [DW-1:0] ram_dat_n = '0;

  // Reference model: granted master index (-1 = none), last winner, stall count
  int m_g    = -1;
  int m_last = N - 1;
  int m_cnt  = 0;

  // Observed grant history
  int            glog [$];
  int            gaps [$];
  int            idle_run = 0;
  logic [N-1:0]  prev_grant = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic [AW-1:0] adr, input logic we, input int nb,
                              input logic [DW-1:0] dat, input logic [3:0] sel);
    txn_t t;
    t.adr = adr; t.we = we; t.nbeats = nb; t.dat = dat; t.sel = sel;
    return t;
  endfunction

  task automatic drive_beat(input int i);
    int b;
    b = m_beat[i];
    wbm_adr_i[i*AW +: AW] = m_cur[i].adr + AW'(b);
    wbm_dat_i[i*DW +: DW] = m_cur[i].dat + DW'(b);
    wbm_sel_i[i*4 +: 4]   = m_cur[i].sel;
    wbm_we_i[i]           = m_cur[i].we;
    wbm_bte_i[i*2 +: 2]   = 2'b00;
    wbm_cti_i[i*3 +: 3]   = (m_cur[i].nbeats == 1) ? 3'b000 :
                            (b == m_cur[i].nbeats - 1) ? 3'b111 : 3'b010;
    wbm_cyc_i[i]          = 1'b1;
    wbm_stb_i[i]          = 1'b1;
  endtask

  task automatic drive_idle(input int i);
    wbm_adr_i[i*AW +: AW] = $urandom;
    wbm_dat_i[i*DW +: DW] = $urandom;
    wbm_sel_i[i*4 +: 4]   = $urandom;
    wbm_we_i[i]           = $urandom;
    wbm_bte_i[i*2 +: 2]   = $urandom;
    wbm_cti_i[i*3 +: 3]   = $urandom;
    wbm_cyc_i[i]          = 1'b0;
    // Non-granted stb without cyc must be ignored
    wbm_stb_i[i]          = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Drive side: one update per cycle, 1 ns after the rising edge
  always @(posedge wb_clk_i) begin
    #1;
    wb_rst_i  = rst_req;
    wbs_ack_i = ram_ack_n;
    wbs_err_i = ram_err_n;
    wbs_dat_i = ram_dat_n;
    for (int i = 0; i < N; i++) begin
      if (rst_req) begin
        m_active[i] = 1'b0;
        m_resp[i]   = 1'b0;
        m_cool[i]   = 0;
        txq[i].delete();
        drive_idle(i);
      end else if (m_active[i]) begin
        if (m_resp[i]) begin
          m_resp[i] = 1'b0;
          if (m_errd[i] || m_beat[i] + 1 >= m_cur[i].nbeats) begin
            m_active[i] = 1'b0;
            m_cool[i]   = rand_mode ? int'($urandom_range(0, 3)) : 0;
            drive_idle(i);
          end else begin
            m_beat[i]++;
            drive_beat(i);
          end
        end
      end else if (m_cool[i] > 0) begin
        m_cool[i]--;
      end else if (txq[i].size() != 0) begin
        m_cur[i]    = txq[i].pop_front();
        m_beat[i]   = 0;
        m_active[i] = 1'b1;
        drive_beat(i);
      end
    end
  end

  // Compare, model update, RAM decision and master sampling on the falling edge
  always @(negedge wb_clk_i) begin
    logic [N-1:0]  e_grant, e_ack, e_err;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [3:0]    e_sel;
    logic [1:0]    e_bte;
    logic [2:0]    e_cti;
    logic          e_we, e_cyc, e_stb, hit;
    e_grant = '0; e_ack = '0; e_err = '0; e_adr = '0; e_dat = '0; e_sel = '0;
    e_bte = '0; e_cti = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; hit = 1'b0;
    if (!wb_rst_i && m_g >= 0) begin
      hit            = TO_EN && (m_cnt == TIMEOUT - 1) && wbm_stb_i[m_g];
      e_grant[m_g]   = 1'b1;
      e_adr          = wbm_adr_i[m_g*AW +: AW];
      e_dat          = wbm_dat_i[m_g*DW +: DW];
      e_sel          = wbm_sel_i[m_g*4 +: 4];
      e_we           = wbm_we_i[m_g];
      e_bte          = wbm_bte_i[m_g*2 +: 2];
      e_cti          = wbm_cti_i[m_g*3 +: 3];
      e_cyc          = wbm_cyc_i[m_g];
      e_stb          = wbm_stb_i[m_g] && !hit;
      e_ack[m_g]     = wbs_ack_i && !hit;
      e_err[m_g]     = wbs_err_i || hit;
    end
    check("grant_o", grant_o, e_grant);
    check("wbs_adr_o", wbs_adr_o, e_adr);
    check("wbs_dat_o", wbs_dat_o, e_dat);
    check("wbs_sel_o", wbs_sel_o, e_sel);
    check("wbs_we_o", wbs_we_o, e_we);
    check("wbs_bte_o", wbs_bte_o, e_bte);
    check("wbs_cti_o", wbs_cti_o, e_cti);
    check("wbs_cyc_o", wbs_cyc_o, e_cyc);
    check("wbs_stb_o", wbs_stb_o, e_stb);
    check("wbm_ack_o", wbm_ack_o, e_ack);
    check("wbm_err_o", wbm_err_o, e_err);
    if (|e_ack) check("wbm_dat_o", wbm_dat_o, wbs_dat_i);

    // Model next state
    if (wb_rst_i) begin
      m_g = -1; m_last = N - 1; m_cnt = 0;
    end else if (m_g < 0) begin
      m_cnt = 0;
      for (int k = 1; k <= N; k++) begin
        if (m_g < 0 && wbm_cyc_i[(m_last + k) % N]) begin
          m_g    = (m_last + k) % N;
          m_last = m_g;
        end
      end
    end else begin
      if (wbs_ack_i || wbs_err_i) m_cnt = 0;
      else if (wbm_stb_i[m_g]) m_cnt++;
      if (!wbm_cyc_i[m_g] || hit) begin
        m_g = -1;
        m_cnt = 0;
      end
    end

    // Grant history
    if (grant_o == '0) begin
      idle_run++;
    end else begin
      if (grant_o != prev_grant) begin
        for (int i = 0; i < N; i++) if (grant_o[i]) glog.push_back(i);
        gaps.push_back(idle_run);
      end
      idle_run = 0;
    end
    prev_grant = grant_o;

    // Masters see their responses
    for (int i = 0; i < N; i++) begin
      if (m_active[i] && (wbm_ack_o[i] || wbm_err_o[i])) begin
        m_resp[i] = 1'b1;
        m_errd[i] = wbm_err_o[i];
        if (wbm_ack_o[i]) begin
          ack_cnt[i]++;
          if (!m_cur[i].we) rd_log[i].push_back(wbm_dat_o);
        end
      end
    end

    // RAM: registered ack one cycle after a fresh request
    ram_ack_n = 1'b0;
    ram_err_n = 1'b0;
    ram_dat_n = $urandom;
    if (wbs_cyc_o && wbs_stb_o && !wbs_ack_i && !wbs_err_i && !ram_stall &&
        (!rand_lat || $urandom_range(0, 3) != 0)) begin
      if (rand_err && $urandom_range(0, 15) == 0) begin
        ram_err_n = 1'b1;
      end else begin
        ram_ack_n = 1'b1;
        ram_dat_n = mem[wbs_adr_o];
        if (wbs_we_o)
          for (int b = 0; b < 4; b++)
            if (wbs_sel_o[b]) mem[wbs_adr_o][8*b +: 8] = wbs_dat_o[8*b +: 8];
      end
    end
  end

  function automatic bit all_idle();
    for (int i = 0; i < N; i++)
      if (m_active[i] || txq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (!all_idle() && c < budget) begin
      @(negedge wb_clk_i);
      c++;
    end
    if (!all_idle()) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: masters still busy after %0d cycles", budget);
    end
    repeat (3) @(negedge wb_clk_i);
  endtask

  task automatic wait_grant(input logic [N-1:0] mask, input int budget);
    int c;
    c = 0;
    while (grant_o !== mask && c < budget) begin
      @(negedge wb_clk_i);
      c++;
    end
    check("wait_grant", grant_o, mask);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    rst_req = 1'b0;
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic clear_logs();
    glog.delete();
    gaps.delete();
    for (int i = 0; i < N; i++) begin
      rd_log[i].delete();
      ack_cnt[i] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] rd;
    int c;
    for (int a = 0; a < (1 << AW); a++) mem[a] = $urandom;
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0; m_resp[i] = 1'b0; m_errd[i] = 1'b0;
      m_beat[i] = 0; m_cool[i] = 0; ack_cnt[i] = 0;
    end

    // Reset values
    repeat (3) @(negedge wb_clk_i);
    check("rst_grant", grant_o, 4'b0000);
    check("rst_wbs_cyc", wbs_cyc_o, 1'b0);
    check("rst_ack", wbm_ack_o, 4'b0000);
    rst_req = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Master 0 write then read, one-cycle arbitration latency
    clear_logs();
    txq[0].push_back(mk(8'h10, 1'b1, 1, 32'hDEADBEEF, 4'hF));
    txq[0].push_back(mk(8'h10, 1'b0, 1, 32'h0, 4'hF));
    c = 0;
    while (!wbm_cyc_i[0] && c < 10) begin @(negedge wb_clk_i); c++; end
    check("t1_grant_at_cyc", grant_o, 4'b0000);
    @(negedge wb_clk_i);
    check("t1_grant_next", grant_o, 4'b0001);
    wait_idle(100);
    rd = (rd_log[0].size() > 0) ? rd_log[0][0] : 'x;
    check("t1_read_data", rd, 32'hDEADBEEF);

    // All four request together after reset: order 0,1,2,3 with one idle cycle between
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) txq[i].push_back(mk(AW'(8'h40 + i), 1'b0, 1, 32'h0, 4'hF));
    wait_idle(200);
    check("t2_grant_count", glog.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("t2_grant_order_%0d", k), glog[k], k);
    for (int k = 1; k < 4; k++) check($sformatf("t2_idle_gap_%0d", k), gaps[k], 1);

    // Master 2 burst holds the grant while master 1 waits
    clear_logs();
    txq[2].push_back(mk(8'h20, 1'b1, 4, 32'h00001000, 4'hF));
    repeat (3) @(negedge wb_clk_i);
    txq[1].push_back(mk(8'h21, 1'b0, 1, 32'h0, 4'hF));
    wait_idle(200);
    check("t3_grant_count", glog.size(), 2);
    check("t3_first_grant", glog[0], 2);
    check("t3_second_grant", glog[1], 1);
    check("t3_burst_acks", ack_cnt[2], 4);
    rd = (rd_log[1].size() > 0) ? rd_log[1][0] : 'x;
    check("t3_burst_readback", rd, 32'h00001001);

    // Wrap: after master 3, masters 0 and 3 together -> 0 first
    txq[3].push_back(mk(8'h50, 1'b0, 1, 32'h0, 4'hF));
    wait_idle(100);
    clear_logs();
    txq[0].push_back(mk(8'h51, 1'b0, 1, 32'h0, 4'hF));
    txq[3].push_back(mk(8'h52, 1'b0, 1, 32'h0, 4'hF));
    wait_idle(100);
    check("t4_wrap_first", glog[0], 0);
    check("t4_wrap_second", glog[1], 3);

    // Reset during a granted burst, with a RAM ack arriving in the reset cycle
    clear_logs();
    txq[2].push_back(mk(8'h30, 1'b1, 4, 32'h00002000, 4'hF));
    wait_grant(4'b0100, 20);
    rst_req = 1'b1;
    @(negedge wb_clk_i);
    check("t5_grant_in_rst", grant_o, 4'b0000);
    check("t5_ack_in_rst", wbm_ack_o, 4'b0000);
    rst_req = 1'b0;
    @(negedge wb_clk_i);
    check("t5_grant_after", grant_o, 4'b0000);
    check("t5_cyc_after", wbs_cyc_o, 1'b0);
    clear_logs();
    txq[1].push_back(mk(8'h60, 1'b0, 1, 32'h0, 4'hF));
    txq[0].push_back(mk(8'h61, 1'b0, 1, 32'h0, 4'hF));
    wait_idle(100);
    check("t5_prio_after_rst", glog[0], 0);

    // Stalled RAM
    ram_stall = 1'b1;
    txq[1].push_back(mk(8'h10, 1'b0, 1, 32'h0, 4'hF));
    wait_grant(4'b0010, 20);
`ifdef MPSOC_WB_ARB_TIMEOUT_EN
    repeat (TIMEOUT - 1) begin
      check("t6_no_err_yet", wbm_err_o, 4'b0000);
      @(negedge wb_clk_i);
    end
    check("t6_err_pulse", wbm_err_o, 4'b0010);
    check("t6_stb_forced", wbs_stb_o, 1'b0);
    @(negedge wb_clk_i);
    check("t6_grant_released", grant_o, 4'b0000);
    ram_stall = 1'b0;
`else
    repeat (20) @(negedge wb_clk_i);
    check("t6_grant_held", grant_o, 4'b0010);
    check("t6_no_err", wbm_err_o, 4'b0000);
    ram_stall = 1'b0;
`endif
    wait_idle(100);

    // Randomized traffic
    rand_mode = 1'b1;
    rand_lat  = 1'b1;
    rand_err  = 1'b1;
    repeat (3000) begin
      @(negedge wb_clk_i);
      for (int i = 0; i < N; i++)
        if (txq[i].size() == 0 && !m_active[i] && $urandom_range(0, 3) == 0)
          txq[i].push_back(mk(AW'($urandom), 1'($urandom), int'($urandom_range(1, 4)),
                              $urandom, 4'($urandom_range(1, 15))));
    end
    wait_idle(2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
